// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS read/write configuration registers.
// All pin inputs are synchronised into clk; sclk edges are detected, never used as clocks.
module spi_reg_bank #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);
    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME      = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(FRAME + 1);
    localparam logic [CNT_W-1:0] CNT_LAST_ADDR  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_LAST_BIT   = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_FIRST_DATA = CNT_W'(ADDR_W + 2);

    logic [SYNC_STAGES-1:0]      sclk_sync_q, copi_sync_q, ncs_sync_q, settle_q;
    logic                        sclk_prev_q, ncs_prev_q, armed_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [FRAME-1:0]            rx_shift_q;
    logic [DATA_W-1:0]           tx_shift_q;
    logic                        rd_active_q, commit_pend_q, err_pend_q;
    logic                        cipo_q, frame_err_q;
    logic [NUM_REGS-1:0]         wr_strobe_q;
    logic [NUM_REGS*DATA_W-1:0]  regs_q;

    logic                        sclk_s, copi_s, ncs_s, live;
    logic                        sclk_rise, sclk_fall, ncs_rise;
    logic [FRAME-1:0]            rx_next;
    logic [DATA_W-1:0]           rd_val;
    logic [NUM_REGS-1:0]         commit_hit;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s  = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s   = ncs_sync_q[SYNC_STAGES-1];
    // armed_q blocks a frame whose ncs fall was lost to reset until ncs is seen high
    assign live      = armed_q & ~ncs_s;
    assign sclk_rise = live & sclk_s & ~sclk_prev_q;
    assign sclk_fall = live & ~sclk_s & sclk_prev_q;
    assign ncs_rise  = armed_q & ncs_s & ~ncs_prev_q;
    assign rx_next   = {rx_shift_q[FRAME-2:0], copi_s};

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_val = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q   <= '0;
            copi_sync_q   <= '0;
            ncs_sync_q    <= '1;
            settle_q      <= '0;
            sclk_prev_q   <= 1'b0;
            ncs_prev_q    <= 1'b1;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rd_active_q   <= 1'b0;
            commit_pend_q <= 1'b0;
            err_pend_q    <= 1'b0;
            cipo_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q   <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q    <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            settle_q      <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q   <= sclk_s;
            ncs_prev_q    <= ncs_s;
            armed_q       <= armed_q | (settle_q[SYNC_STAGES-1] & ncs_s);
            commit_pend_q <= 1'b0;
            err_pend_q    <= ncs_rise && (cnt_q != CNT_FRAME);
            frame_err_q   <= err_pend_q;
            cipo_q        <= rd_active_q & tx_shift_q[DATA_W-1];
            if (!live) begin
                cnt_q       <= '0;
                rd_active_q <= 1'b0;
            end else if (sclk_rise) begin
                if (cnt_q != CNT_MAX)      cnt_q <= cnt_q + 1'b1;
                if (cnt_q < CNT_FRAME)     rx_shift_q <= rx_next;
                if (cnt_q == CNT_LAST_ADDR) begin
                    tx_shift_q  <= rd_val;
                    rd_active_q <= ~rx_next[ADDR_W];
                end
                if (cnt_q == CNT_LAST_BIT) commit_pend_q <= 1'b1;
            end else if (sclk_fall && rd_active_q && cnt_q >= CNT_FIRST_DATA) begin
                // the fall right after the last address bit must keep the MSB for the next rise
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
        assign commit_hit[gi] = commit_pend_q && rx_shift_q[FRAME-1] &&
                                (rx_shift_q[FRAME-2 -: ADDR_W] == ADDR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q      <= RESET_VAL;
            wr_strobe_q <= '0;
        end else begin
            wr_strobe_q <= commit_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_hit[i]) regs_q[i*DATA_W +: DATA_W] <= rx_shift_q[DATA_W-1:0];
            end
        end
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = ~ncs_s;
    assign reg_out   = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised scoreboard bench for spi_reg_bank: a bit-level SPI controller drives frames,
// an array model predicts register contents, strobes, frame errors and read data.
`timescale 1ns/1ps
module tb_spi_reg_bank;
    localparam int HP = 6;
    localparam logic [39:0] RV = 40'h00_00_7E_00_00;

    typedef struct packed {
        logic [4:0]  strobe;
        logic [39:0] img;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n, sclk, copi, ncs;
    logic        cipo, cipo_oe, frame_err;
    logic [39:0] reg_out;
    logic [4:0]  wr_strobe;

    int total = 0;
    int bad = 0;
    bit ignore_err = 1'b0;

    logic [7:0]  model_regs [5];
    wr_exp_t     exp_wr_q [$];
    int          exp_err_q [$];
    logic [15:0] exp_rd_q [$];
    logic [15:0] obs_rd_q [$];

    spi_reg_bank #(
        .ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .reg_out(reg_out),
        .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model_img();
        logic [39:0] v;
        for (int i = 0; i < 5; i++) v[i*8 +: 8] = model_regs[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) model_regs[i] = RV[i*8 +: 8];
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic smp);
        copi = b;
        wait_clk(HP);
        smp  = cipo;
        sclk = 1'b1;
        wait_clk(HP);
        sclk = 1'b0;
    endtask

    // Full transaction: predictions are pushed first, then the frame is clocked out.
    task automatic run_frame(input int nbits, input logic [15:0] hdr);
        logic [31:0] w;
        logic [31:0] extra;
        logic [15:0] s;
        logic [15:0] rexp;
        logic [7:0]  mask;
        logic [6:0]  addr;
        logic        b;
        wr_exp_t     e;
        addr  = hdr[14:8];
        extra = $urandom;
        w = {16'h0, hdr};
        if (nbits >= 16) w = (w << (nbits - 16)) | (extra & ((32'd1 << (nbits - 16)) - 1));
        else             w = w >> (16 - nbits);
        rexp = '0;
        if (!hdr[15] && nbits >= 9) begin
            mask = 8'hFF;
            if (nbits < 16) mask = mask << (16 - nbits);
            rexp[7:0] = ((addr < 5) ? model_regs[addr] : 8'h00) & mask;
        end
        exp_rd_q.push_back(rexp);
        if (hdr[15] && nbits >= 16 && addr < 5) begin
            model_regs[addr] = hdr[7:0];
            e.strobe = 5'b00001 << addr;
            e.img    = model_img();
            exp_wr_q.push_back(e);
        end
        if (nbits != 16) exp_err_q.push_back(nbits);
        ncs = 1'b0;
        wait_clk(HP);
        s = '0;
        for (int p = 0; p < nbits; p++) begin
            send_bit(w[nbits-1-p], b);
            if (p < 16) s[15-p] = b;
        end
        wait_clk(HP);
        ncs = 1'b1;
        wait_clk(3 * HP);
        obs_rd_q.push_back(s);
        $display("frame bits=%0d hdr=%04h cipo_word=%04h", nbits, hdr, s);
        check("regs_after_frame", reg_out, model_img());
        check("cipo_idle", cipo, 1'b0);
        check("cipo_oe_idle", cipo_oe, 1'b0);
    endtask

    // Monitor: pops predictions whenever the DUT presents an output event.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (wr_strobe != 5'b0) begin
                    if (exp_wr_q.size() == 0) begin
                        check("unexpected_strobe", wr_strobe, 5'b0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("wr_strobe", wr_strobe, e.strobe);
                        check("reg_out_at_strobe", reg_out, e.img);
                    end
                end
                if (frame_err && !ignore_err) begin
                    if (exp_err_q.size() == 0) check("unexpected_frame_err", frame_err, 1'b0);
                    else void'(exp_err_q.pop_front());
                end
                if (obs_rd_q.size() != 0) begin
                    if (exp_rd_q.size() == 0) check("unexpected_read", obs_rd_q.pop_front(), 16'h0);
                    else check("cipo_read_word", obs_rd_q.pop_front(), exp_rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        b;
        logic [6:0]  a;
        logic [15:0] hdr;
        int          nb;
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        model_reset();
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(4);
        check("reset_reg_out", reg_out, RV);
        check("reset_cipo", cipo, 1'b0);
        check("reset_cipo_oe", cipo_oe, 1'b0);
        check("reset_strobe", wr_strobe, 5'b0);
        check("reset_frame_err", frame_err, 1'b0);

        run_frame(16, 16'h80F0);
        run_frame(16, 16'h8455);
        run_frame(16, 16'h0400);
        run_frame(16, 16'h86AA);
        run_frame(16, 16'h0600);
        run_frame(10, 16'h8123);
        run_frame(17, 16'h813C);

        for (int n = 0; n < 30; n++) begin
            a = 7'($urandom_range(0, 9));
            if (a > 7) a = 7'($urandom_range(5, 127));
            hdr = {1'($urandom_range(0, 1)), a, 8'($urandom)};
            case ($urandom_range(0, 7))
                0:       nb = 10;
                1:       nb = 17;
                2:       nb = 19;
                default: nb = 16;
            endcase
            run_frame(nb, hdr);
        end

        // Reset in the middle of a frame, then a full frame without ncs going high first.
        run_frame(16, 16'h8211);
        ncs = 1'b0;
        wait_clk(HP);
        for (int p = 0; p < 6; p++) send_bit(p[0], b);
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        model_reset();
        wait_clk(4);
        check("midframe_reset_regs", reg_out, RV);
        ignore_err = 1'b1;
        hdr = 16'h8399;
        for (int p = 0; p < 16; p++) send_bit(hdr[15-p], b);
        wait_clk(HP);
        ncs = 1'b1;
        wait_clk(3 * HP);
        ignore_err = 1'b0;
        check("unarmed_frame_ignored", reg_out, RV);
        run_frame(16, 16'h0200);
        run_frame(16, 16'h8399);
        run_frame(16, 16'h0300);

        wait_clk(10);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("err_queue_drained", exp_err_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
